// File: rtl/rv32m_pkg.sv
// Shared RV32M divide definitions: funct3 encodings, word constants and the
// front-end state type.
package rv32m_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  localparam logic [XLEN-1:0] WORD_MIN  = 32'h8000_0000;
  localparam logic [XLEN-1:0] WORD_ONES = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE,
    CORE_START,
    CORE_WAIT,
    DRAIN,
    FIXUP,
    RESP
  } div_state_t;

endpackage

// File: rtl/div_unit_if.sv
// Request/response bundle between the execute stage (master) and div_unit (slave).
interface div_unit_if #(parameter int unsigned TAG_W = 5);

  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_funct3;
  logic [31:0]      req_rs1;
  logic [31:0]      req_rs2;
  logic [TAG_W-1:0] req_tag;
  logic             flush;
  logic             resp_valid;
  logic             resp_ready;
  logic [31:0]      resp_data;
  logic [TAG_W-1:0] resp_tag;
  logic             busy;

  modport master (
    output req_valid, req_funct3, req_rs1, req_rs2, req_tag, flush, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_tag, busy
  );

  modport slave (
    input  req_valid, req_funct3, req_rs1, req_rs2, req_tag, flush, resp_ready,
    output req_ready, resp_valid, resp_data, resp_tag, busy
  );

endinterface

// File: rtl/div_unit_divider.sv
// Unsigned iterative restoring divider, four quotient bits per cycle.
// Divisor must be below 2**31; start-to-done latency is 10 clocks.
module divider
  import rv32m_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-2:0] b,
  output logic            done,
  output logic [XLEN-1:0] q,
  output logic [XLEN-1:0] r
);

  localparam int unsigned STEPS = 4;
  localparam int unsigned ITERS = XLEN / STEPS;

  logic [XLEN-2:0] dsr;
  logic [2:0]      cnt;
  logic            run;
  logic [XLEN-1:0] q_n;
  logic [XLEN-1:0] r_n;

  // q doubles as the dividend shift register; the remainder never exceeds 31 bits
  always_comb begin
    q_n = q;
    r_n = r;
    for (int unsigned i = 0; i < STEPS; i++) begin
      r_n = {r_n[XLEN-2:0], q_n[XLEN-1]};
      q_n = {q_n[XLEN-2:0], 1'b0};
      if (r_n >= {1'b0, dsr}) begin
        r_n    = r_n - {1'b0, dsr};
        q_n[0] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run  <= 1'b0;
      done <= 1'b0;
      cnt  <= '0;
      dsr  <= '0;
      q    <= '0;
      r    <= '0;
    end else begin
      done <= 1'b0;
      if (start && !run) begin
        q   <= a;
        r   <= '0;
        dsr <= b;
        cnt <= '0;
        run <= 1'b1;
      end else if (run) begin
        q   <= q_n;
        r   <= r_n;
        cnt <= cnt + 3'd1;
        if (cnt == 3'(ITERS - 1)) begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/div_unit.sv
// RV32M DIV/DIVU/REM/REMU front-end: sign handling and corner cases around the
// unsigned iterative divider core, with a held response and flush support.
module div_unit
  import rv32m_pkg::*;
#(
  parameter int unsigned TAG_W = 5
) (
  input  logic      clk,
  input  logic      rst,
  div_unit_if.slave bus
);

  div_state_t      state;
  logic            op_rem, sa_q, sb_q;
  logic [XLEN-1:0] a_mag, qm, rm;
  logic [XLEN-2:0] b_mag;
  logic [TAG_W-1:0] tag_q;
  logic            core_start, core_done;
  logic [XLEN-1:0] core_q, core_r;

  logic            signed_op, rem_op, sa, sb, accept, bypass, bp_sa, bp_sb, ge;
  logic [XLEN-1:0] abs_a, abs_b, bp_q, bp_r, q_fix, r_fix;
  logic            unused_f3;

  assign unused_f3 = bus.req_funct3[2];

  // Operand decode and the cases resolved without the core
  always_comb begin
    signed_op = ~bus.req_funct3[0];
    rem_op    = bus.req_funct3[1];
    sa        = signed_op & bus.req_rs1[XLEN-1];
    sb        = signed_op & bus.req_rs2[XLEN-1];
    abs_a     = sa ? (32'd0 - bus.req_rs1) : bus.req_rs1;
    abs_b     = sb ? (32'd0 - bus.req_rs2) : bus.req_rs2;
    ge        = (abs_a >= abs_b);
    accept    = bus.req_valid & bus.req_ready & ~bus.flush;
    bypass    = 1'b1;
    bp_sa     = sa;
    bp_sb     = sb;
    bp_q      = '0;
    bp_r      = '0;
    if (bus.req_rs2 == '0) begin
      bp_q  = WORD_ONES;
      bp_r  = bus.req_rs1;
      bp_sa = 1'b0;
      bp_sb = 1'b0;
    end else if (signed_op && bus.req_rs1 == WORD_MIN && bus.req_rs2 == WORD_ONES) begin
      bp_q  = WORD_MIN;
      bp_sa = 1'b0;
      bp_sb = 1'b0;
    end else if (abs_b[XLEN-1]) begin
      bp_q = {31'd0, ge};
      bp_r = abs_a - (ge ? abs_b : 32'd0);
    end else begin
      bypass = 1'b0;
    end
  end

  always_comb begin
    q_fix = (sa_q ^ sb_q) ? (32'd0 - qm) : qm;
    r_fix = sa_q ? (32'd0 - rm) : rm;
  end

  divider u_core (
    .clk   (clk),
    .rst   (rst),
    .start (core_start),
    .a     (a_mag),
    .b     (b_mag),
    .done  (core_done),
    .q     (core_q),
    .r     (core_r)
  );

  // Control FSM; req_ready/busy are updated only on transitions into or out of IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      bus.req_ready  <= 1'b1;
      bus.busy       <= 1'b0;
      bus.resp_valid <= 1'b0;
      bus.resp_data  <= '0;
      bus.resp_tag   <= '0;
      core_start     <= 1'b0;
      op_rem         <= 1'b0;
      sa_q           <= 1'b0;
      sb_q           <= 1'b0;
      a_mag          <= '0;
      b_mag          <= '0;
      qm             <= '0;
      rm             <= '0;
      tag_q          <= '0;
    end else begin
      core_start <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          op_rem        <= rem_op;
          tag_q         <= bus.req_tag;
          a_mag         <= abs_a;
          b_mag         <= abs_b[XLEN-2:0];
          bus.req_ready <= 1'b0;
          bus.busy      <= 1'b1;
          if (bypass) begin
            sa_q  <= bp_sa;
            sb_q  <= bp_sb;
            qm    <= bp_q;
            rm    <= bp_r;
            state <= FIXUP;
          end else begin
            sa_q       <= sa;
            sb_q       <= sb;
            core_start <= 1'b1;
            state      <= CORE_START;
          end
        end
        CORE_START: state <= bus.flush ? DRAIN : CORE_WAIT;
        CORE_WAIT: begin
          if (bus.flush && core_done) begin
            state         <= IDLE;
            bus.req_ready <= 1'b1;
            bus.busy      <= 1'b0;
          end else if (bus.flush) begin
            state <= DRAIN;
          end else if (core_done) begin
            qm    <= core_q;
            rm    <= core_r;
            state <= FIXUP;
          end
        end
        // The core cannot abort; wait out its result and drop it
        DRAIN: if (core_done) begin
          state         <= IDLE;
          bus.req_ready <= 1'b1;
          bus.busy      <= 1'b0;
        end
        FIXUP: begin
          if (bus.flush) begin
            state         <= IDLE;
            bus.req_ready <= 1'b1;
            bus.busy      <= 1'b0;
          end else begin
            bus.resp_data  <= op_rem ? r_fix : q_fix;
            bus.resp_tag   <= tag_q;
            bus.resp_valid <= 1'b1;
            state          <= RESP;
          end
        end
        RESP: if (bus.flush || bus.resp_ready) begin
          bus.resp_valid <= 1'b0;
          state          <= IDLE;
          bus.req_ready  <= 1'b1;
          bus.busy       <= 1'b0;
        end
        default: begin
          state         <= IDLE;
          bus.req_ready <= 1'b1;
          bus.busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases, flush, reset and
// randomized operations against an arithmetic reference model.
module tb_div_unit;
  import rv32m_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   start_cnt = 0;

  always #5 clk = ~clk;

  div_unit_if #(.TAG_W(5)) bus ();

  div_unit #(.TAG_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always @(posedge clk) if (dut.core_start) start_cnt <= start_cnt + 1;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // RISC-V division semantics via 64-bit arithmetic (truncating division)
  function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint x, y, q, r;
    if (b == 32'd0) return f3[1] ? a : 32'hFFFF_FFFF;
    if (f3[0]) begin
      x = longint'({32'd0, a});
      y = longint'({32'd0, b});
    end else begin
      x = longint'($signed(a));
      y = longint'($signed(b));
    end
    q = x / y;
    r = x % y;
    return f3[1] ? r[31:0] : q[31:0];
  endfunction

  // Ops resolved without the iterative core: zero divisor, overflow, divisor magnitude >= 2**31
  function automatic bit ref_bypass(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint mb;
    if (b == 32'd0) return 1'b1;
    if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1'b1;
    if (f3[0]) mb = longint'({32'd0, b});
    else begin
      mb = longint'($signed(b));
      if (mb < 0) mb = -mb;
    end
    return mb > 2147483647;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 100));
      default: return 32'($urandom());
    endcase
  endfunction

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
    int n = 0;
    while (!bus.req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("req_ready_before_issue", 32'(bus.req_ready), 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_funct3 = f3;
    bus.req_rs1    = a;
    bus.req_rs2    = b;
    bus.req_tag    = tag;
    @(posedge clk); #1;
    bus.req_valid  = 1'b0;
  endtask

  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input int hold);
    logic [31:0] exp_d;
    int exp_lat, lat, s0;
    exp_d   = ref_res(f3, a, b);
    exp_lat = ref_bypass(f3, a, b) ? 2 : 12;
    s0      = start_cnt;
    issue(f3, a, b, tag);
    lat = 1;
    while (!bus.resp_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("resp_data", bus.resp_data, exp_d);
    check("resp_tag", 32'(bus.resp_tag), 32'(tag));
    check("core_starts", 32'(start_cnt - s0), (exp_lat == 2) ? 32'd0 : 32'd1);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", 32'(bus.resp_valid), 32'd1);
      check("hold_data", bus.resp_data, exp_d);
      check("hold_tag", 32'(bus.resp_tag), 32'(tag));
    end
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    check("consumed_valid", 32'(bus.resp_valid), 32'd0);
    check("ready_after_consume", 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    int  drop, saw_valid, s0;
    logic [2:0] f3;
    rst            = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_rs1    = 32'd0;
    bus.req_rs2    = 32'd0;
    bus.req_tag    = 5'd0;
    bus.flush      = 1'b0;
    bus.resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_data", bus.resp_data, 32'd0);
    check("rst_resp_tag", 32'(bus.resp_tag), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    rst = 1'b0;

    // Directed core-path and bypass cases
    run_op(F3_DIVU, 32'd100, 32'd7, 5'd3, 0);
    run_op(F3_REMU, 32'd100, 32'd7, 5'd4, 0);
    run_op(F3_DIV, 32'hFFFF_FFF9, 32'd2, 5'd5, 0);
    run_op(F3_REM, 32'hFFFF_FFF9, 32'd2, 5'd6, 0);
    run_op(F3_REM, 32'd7, 32'hFFFF_FFFE, 5'd7, 0);
    run_op(F3_DIV, 32'd5, 32'd0, 5'd8, 0);
    run_op(F3_REM, 32'd5, 32'd0, 5'd9, 0);
    run_op(F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 0);
    run_op(F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 0);
    run_op(F3_DIVU, 32'hFFFF_FFFF, 32'h8000_0000, 5'd12, 0);
    run_op(F3_REMU, 32'hFFFF_FFFF, 32'h8000_0000, 5'd13, 0);
    run_op(F3_DIV, 32'h8000_0000, 32'h8000_0000, 5'd14, 0);

    // Flush four clocks after accept: core result must be drained and discarded
    s0 = start_cnt;
    issue(F3_DIVU, 32'd1000, 32'd10, 5'd15);
    drop = 0;
    saw_valid = 0;
    for (int k = 1; k <= 30; k++) begin
      bus.flush = (k == 4);
      @(posedge clk); #1;
      bus.flush = 1'b0;
      if (bus.resp_valid) saw_valid = 1;
      if (!bus.busy && drop == 0) drop = k;
    end
    check("flush_no_resp", 32'(saw_valid), 32'd0);
    check("flush_busy_until_done", 32'(drop), 32'd10);
    check("flush_core_started", 32'(start_cnt - s0), 32'd1);
    run_op(F3_DIVU, 32'd9, 32'd3, 5'd16, 0);

    // Backpressured response held for five cycles
    run_op(F3_DIV, 32'hFFFF_FC18, 32'd7, 5'd17, 5);

    // Reset in the middle of a core operation
    issue(F3_DIVU, 32'd12345, 32'd17, 5'd18);
    repeat (3) @(posedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("midrst_req_ready", 32'(bus.req_ready), 32'd1);

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      f3 = F3_DIV | 3'($urandom_range(0, 3));
      run_op(f3, pick(), pick(), 5'($urandom_range(0, 31)), $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- RV32M front-end for the execute stage: accepts DIV/DIVU/REM/REMU operations and returns one 32-bit result per request.
- Converts signed operands to magnitudes before driving the unsigned iterative divider core over its start/done handshake, then sign-corrects its q/r.
- Resolves divide-by-zero, signed overflow and divisor-bit-31 cases without the core, because the core only uses divisor[30:0].
- Holds the request until the pipeline takes the response; supports flush on redirect.

Parameters:
TAG_W, 5, width of the opaque tag (destination register index) carried from request to response

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  unit can accept; high only in IDLE
req_funct3  in  3  100 DIV, 101 DIVU, 110 REM, 111 REMU; bit2 ignored
req_rs1  in  32  dividend
req_rs2  in  32  divisor
req_tag  in  TAG_W  tag returned with the result
flush  in  1  kill the in-flight op
resp_valid  out  1  result valid; held until accepted
resp_ready  in  1  consumer takes the result
resp_data  out  32  quotient or remainder
resp_tag  out  TAG_W  tag of the result
busy  out  1  state != IDLE

Behaviour:
- Reset: state IDLE; resp_valid=0, resp_data=0, resp_tag=0, busy=0, core start=0. Reset mid-operation: same result, in-flight op dropped.
- Accept: occurs when req_valid & req_ready. Register op (signed = ~funct3[0], rem = funct3[1]), tag, sa = signed & rs1[31], sb = signed & rs2[31], |a| and |b|. Magnitudes are two's-complement negation, 32-bit wrap, so |0x80000000| = 0x80000000.
- Classification is combinational on the accept cycle, with this priority:
  1. rs2 == 0: q = 0xFFFFFFFF, r = rs1 (raw), no sign fix.
  2. signed, rs1 == 0x80000000, rs2 == 0xFFFFFFFF: q = 0x80000000, r = 0.
  3. |b|[31] == 1: qm = (|a| >= |b|), rm = |a| - (qm ? |b| : 0), then sign fix.
  4. Otherwise: core path.
  Cases 1–3 take the bypass path: IDLE -> FIXUP -> RESP.
- Core path: IDLE -> CORE_START -> CORE_WAIT -> FIXUP -> RESP.
  - CORE_START: core start=1 for exactly one cycle, with a = |a| and b = |b|.
  - CORE_WAIT: start=0; wait for the one-cycle core done pulse and latch qm/rm on it.
  - start is never asserted while core done=1 or in any other state.
- FIXUP (one cycle): q = (sa^sb) ? -qm : qm; r = sa ? -rm : rm. resp_data <= rem ? r : q. resp_valid <= 1 on entry to RESP.
- RESP: resp_data and resp_tag are stable while resp_valid & ~resp_ready. On resp_ready, go to IDLE with resp_valid=0.
- Latency, measured from the accept edge to resp_valid high:
  - Bypass: 2 clocks.
  - Core path: 12 clocks with the current 4-step/cycle core, i.e. core latency (10) + 2.
- Back-to-back: req_ready rises the cycle after the response is consumed. There is no overlap.
- Flush:
  - IDLE: no accept that cycle.
  - CORE_START/CORE_WAIT: go to DRAIN. The core cannot abort, so stay in DRAIN until its done pulse, discard the result, then IDLE.
  - DRAIN: busy=1, req_ready=0.
  - FIXUP/RESP: go to IDLE next cycle and clear resp_valid. A flush coinciding with resp_ready in RESP wins; the consumer ignores that response.
- Done pulse arriving in the same cycle as a flush in CORE_WAIT: discard the result and go straight to IDLE.
- Encodings with funct3[2]=0 are decoded on bits [1:0] only; the issue stage guarantees MUL ops never reach this unit.

Decomposition:
- Shared package (rv32m_pkg): funct3 localparams for DIV/DIVU/REM/REMU; div_state_t enum {IDLE, CORE_START, CORE_WAIT, DRAIN, FIXUP, RESP}; 32'h8000_0000 and all-ones constants.
- One sub-module: the existing unsigned iterative divider core (divider), instanced once. The bypass compare/subtract and the sign fix are inline logic, not separate modules.

Test Plan:
- DIVU 100/7, tag 3 -> resp_data 14, tag 3, 12 clocks after accept. REMU same operands -> 2.
- DIV -7/2 -> 0xFFFFFFFD. REM -7/2 -> 0xFFFFFFFF. REM 7/-2 -> 1.
- DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000; REM 0x80000000/-1 -> 0. All 2-clock latency, core start never pulses.
- DIVU 0xFFFFFFFF/0x80000000 -> 1; REMU same operands -> 0x7FFFFFFF; DIV 0x80000000/0x80000000 -> 1. All 2-clock latency.
- DIVU 1000/10 with flush 4 clocks after accept -> no resp_valid, busy held until core done, then IDLE. Next DIVU 9/3 -> 3, no stale data.
- Core-path response with resp_ready low for 5 cycles -> resp_valid, resp_data, resp_tag stable. Consumed on the 6th cycle, req_ready=1 the next cycle.
